// File: rtl/alu_share_sched_if.sv
// alu_share_sched_if
// Bundles the two requester command/response channels, the ALU macro
// operand/result lines and the busy flag for alu_share_sched.
//   slave  : scheduler side (drives ready, rsp*, alu_a/b/sel, busy)
//   master : requester/ALU side (drives valid, operands, rsp ready, alu_y)
interface alu_share_sched_if;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [1:0] req0_sel;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [1:0] req1_sel;
  logic       rsp0_valid, rsp0_ready;
  logic [4:0] rsp0_y;
  logic       rsp1_valid, rsp1_ready;
  logic [4:0] rsp1_y;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [4:0] alu_y;
  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready, alu_y,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
    output alu_a, alu_b, alu_sel, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready, alu_y,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
    input  alu_a, alu_b, alu_sel, busy
  );
endinterface

// File: rtl/alu_share_sched.sv
// alu_share_sched
// Time-shares one external 4-bit ALU between two requesters. One operation
// in flight at a time: IDLE (arbitrate/accept) -> EXEC (wait ALU_LAT) ->
// RESP (hold result until the owner takes it).
// Ports:
//   wb_clk_i : clock, rising edge
//   resetb   : asynchronous active-low reset
//   bus      : alu_share_sched_if.slave (requests, responses, ALU, busy)
// Parameters:
//   ALU_LAT  : 0..3 cycles between driving alu_a/b/sel and sampling alu_y
// Build option:
//   ALU_SHARE_FIXED_PRIO_EN : defined -> req0 always wins a tie;
//                             undefined -> round-robin on last_grant.
module alu_share_sched #(
  parameter int ALU_LAT = 1
) (
  input logic              wb_clk_i,
  input logic              resetb,
  alu_share_sched_if.slave bus
);
  localparam logic [1:0] LAT = 2'(ALU_LAT);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t state_q, state_d;

  logic [1:0]      req_v, rsp_rdy, rdy, rsp_v;
  logic [1:0][3:0] req_a, req_b;
  logic [1:0][1:0] req_sel;
  logic [1:0][4:0] rsp_y_q;
  logic [3:0]      alu_a_q, alu_b_q;
  logic [1:0]      alu_sel_q, lat_cnt_q;
  logic            owner_q, win, accept, exec_done, rsp_hs, busy;

  assign req_v   = {bus.req1_valid, bus.req0_valid};
  assign req_a   = {bus.req1_a, bus.req0_a};
  assign req_b   = {bus.req1_b, bus.req0_b};
  assign req_sel = {bus.req1_sel, bus.req0_sel};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

  // Arbiter: win is only meaningful while at least one valid is high.
`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign win = ~req_v[0];
`else
  logic last_grant_q;
  always_comb begin
    if (&req_v) win = ~last_grant_q;  // tie: the other one goes
    else        win = req_v[1];
  end
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb)     last_grant_q <= 1'b1;  // req0 takes the first tie
    else if (accept) last_grant_q <= win;
  end
`endif

  assign accept    = |(rdy & req_v);
  assign exec_done = (state_q == EXEC) && (lat_cnt_q == LAT);
  assign rsp_hs    = (state_q == RESP) && rsp_rdy[owner_q];

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_hs)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs. ready is gated by resetb so it reads 0 throughout reset.
  always_comb begin
    rdy   = '0;
    rsp_v = '0;
    busy  = (state_q != IDLE);
    case (state_q)
      IDLE:    if (resetb && |req_v) rdy[win] = 1'b1;
      RESP:    rsp_v[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, latency count, result capture
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      owner_q   <= 1'b0;
      lat_cnt_q <= '0;
      rsp_y_q   <= '0;
    end else begin
      if (accept) begin
        alu_a_q   <= req_a[win];
        alu_b_q   <= req_b[win];
        alu_sel_q <= req_sel[win];
        owner_q   <= win;
        lat_cnt_q <= '0;
      end else if (state_q == EXEC && !exec_done) begin
        lat_cnt_q <= lat_cnt_q + 2'd1;
      end
      if (exec_done) rsp_y_q[owner_q] <= bus.alu_y;
    end
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rsp0_valid = rsp_v[0];
  assign bus.rsp1_valid = rsp_v[1];
  assign bus.rsp0_y     = rsp_y_q[0];
  assign bus.rsp1_y     = rsp_y_q[1];
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.busy       = busy;
endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Scheduler that time-shares a single external 4-bit ALU macro between two requesters. Each requester has a valid/ready command channel and a valid/ready response channel. The block arbitrates between the two, registers and drives the winner's operands and op-select onto the ALU, waits a configurable ALU latency, captures the 5-bit result, and returns it to the issuing requester. It sits between the user-project I/O or logic-analyzer front end and the ALU macro inside the user area.

## Interface
Parameters:
- `ALU_LAT`, default 1: cycles between the ALU operands being driven and `alu_y` being sampled. Legal range 0..3; 0 means a combinational ALU.

Ports:
- `wb_clk_i`  in  1  sole clock; all logic is on the rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 command valid.
- `req0_ready`  out  1  requester 0 command accepted.
- `req0_a`, `req0_b`  in  4 each  requester 0 operands.
- `req0_sel`  in  2  requester 0 op select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as above, for requester 1.
- `rsp0_valid`  out  1  result valid for requester 0.
- `rsp0_ready`  in  1  requester 0 accepts the result.
- `rsp0_y`  out  5  result for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_y`: same as above, for requester 1.
- `alu_a`, `alu_b`  out  4 each  ALU operands (registered).
- `alu_sel`  out  2  ALU op select (registered).
- `alu_y`  in  5  ALU result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Only one operation is in flight at a time.
- IDLE: the arbiter picks a winner among the asserted `reqN_valid`.
  - `reqN_ready` is 1 only in IDLE and only for the winner.
  - `reqN_ready` is combinational from the state, both valids and `last_grant`.
  - On accept (valid & ready), the winner's a/b/sel are registered into `alu_*`, `owner` is set to N, `lat_cnt` is cleared, and the FSM goes to EXEC.
- EXEC: `lat_cnt` increments each cycle.
  - When `lat_cnt == ALU_LAT`, `alu_y` is captured into the owner's `rsp_y` register, `rspN_valid` is set, and the FSM goes to RESP.
- RESP: `rsp<owner>_valid` is held with `rsp_y` stable until `rsp<owner>_ready`.
  - On that handshake, `rspN_valid` clears and the FSM returns to IDLE.
  - The next command can be accepted no earlier than the following cycle.
- The non-owner's `rsp_valid` is always 0. `rsp_y` holds its last value after the handshake.
- `alu_a`, `alu_b` and `alu_sel` hold the last issued values until the next accept.
- Round-robin arbitration: `last_grant` records the last winner. On a tie, the other requester wins. A sole requester always wins.
- `last_grant` updates only on accept.
- No arithmetic is done in this block; `alu_y` passes through unmodified.

## Timing
- Reset values:
  - `req*_ready` = 0 while `resetb` is low; combinational afterwards.
  - `rsp*_valid` = 0, `rsp*_y` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_sel` = 0, `busy` = 0.
  - State = IDLE, `last_grant` = 1, so req0 wins the first tie.
- Accept in cycle N:
  - `alu_*` are valid from N+1.
  - `alu_y` is sampled at the end of cycle N+1+ALU_LAT.
  - `rspN_valid` goes high in cycle N+2+ALU_LAT.
- Minimum issue interval with `rsp_ready` tied high is 3+ALU_LAT cycles.
- A requester may drop `valid` before ready with no effect. Commands are not latched until accept.
- Reset asserted mid-operation aborts immediately. The FSM returns to IDLE, no response is produced, and the in-flight result is discarded.
- `rspN_ready` asserted while `rspN_valid` is low is ignored.

## Configuration
- `ALU_SHARE_FIXED_PRIO_EN`:
  - Defined: fixed priority. req0 always wins when both are valid, and `last_grant` is not implemented.
  - Undefined (default): round-robin as described under Operation.

## Test plan
The bench ALU model is: sel 00 add, 01 sub mod 32, 10 AND, 11 OR, with output zero-extended to 5 bits.

- Single add: `req0` with a=9, b=9, sel=00, `ALU_LAT`=1, `rsp0_ready`=1 → `rsp0_valid` rises 3 cycles after accept with `rsp0_y`=5'b10010; `rsp1_valid` stays 0.
- Tie round-robin: both requests held valid continuously (req0: 3+4; req1: 15 OR 0) → grants alternate 0,1,0,1; `rsp0_y`=7, `rsp1_y`=15.
- Backpressure: `rsp1_ready`=0 for 5 cycles with `req0_valid` held → `rsp1_y` stable, `req0_ready` stays 0 until one cycle after the rsp1 handshake.
- Latency sweep: `ALU_LAT` = 0 and 3 → `rsp_valid` at accept+2 and accept+5 respectively.
- Reset mid-EXEC: `resetb` pulsed low during EXEC → all outputs return to reset values, no response is produced, and the first tie afterwards grants req0.
- `ALU_SHARE_FIXED_PRIO_EN` defined, both requesters valid for 4 operations → all 4 granted to req0, req1 granted only after `req0_valid` drops.
